// File: rtl/sample_packer.sv
// sample_packer: accumulates 2-bit three-channel I/Q or raw 8-bit ch1 samples
// into 16-bit words and frames them into fixed-length packets. The format is
// relatched only on packet boundaries, so a packet never mixes formats.
module sample_packer #(
    parameter int unsigned WORDS_PER_PACKET = 720
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ch1_si,
    input  logic [1:0]  ch1_sq,
    input  logic [1:0]  ch2_si,
    input  logic [1:0]  ch2_sq,
    input  logic [1:0]  ch3_si,
    input  logic [1:0]  ch3_sq,
    input  logic [7:0]  ch1_i,
    input  logic [7:0]  ch1_q,
    input  logic [7:0]  mode,
    input  logic        enable,
    output logic [15:0] data,
    output logic        en,
    output logic        packet_end,
    output logic        active,
    output logic [15:0] packet_count
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned FILL_W = 5;
    localparam int unsigned CNT_W  = $clog2(WORDS_PER_PACKET);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic [ACC_W-1:0]   acc_q;
    logic [FILL_W-1:0]  fill_q;
    logic [1:0]         phase_q;
    logic [CNT_W-1:0]   word_cnt_q;

    logic [11:0]        new_bits_c;
    logic [FILL_W-1:0]  new_w_c;
    logic [ACC_W-1:0]   merged_c;
    logic [FILL_W-1:0]  merged_fill_c;
    logic               emit_c;
    logic [WORD_W-1:0]  word_c;
    logic [FILL_W-1:0]  rem_fill_c;
    logic [ACC_W-1:0]   acc_next_c;
    logic [1:0]         phase_next_c;
    logic               last_word_c;
    logic               mode_ok_c;

    // Append this cycle's sample bits under the oldest bits and split off a word
    always_comb begin
        new_bits_c    = 12'h000;
        new_w_c       = FILL_W'(8);
        phase_next_c  = {1'b0, ~phase_q[0]};
        emit_c        = phase_q[0];
        case (mode_q)
            2'd0: begin
                new_bits_c   = {ch1_si, ch1_sq, ch2_si, ch2_sq, ch3_si, ch3_sq};
                new_w_c      = FILL_W'(12);
                phase_next_c = phase_q + 2'd1;
                emit_c       = (phase_q != 2'd0);
            end
            2'd1:    new_bits_c = {4'h0, ch1_i};
            default: new_bits_c = {4'h0, ch1_q};
        endcase

        merged_c      = (acc_q << new_w_c) | ACC_W'(new_bits_c);
        merged_fill_c = fill_q + new_w_c;
        word_c        = WORD_W'(merged_c >> (merged_fill_c - FILL_W'(WORD_W)));
        rem_fill_c    = emit_c ? (merged_fill_c - FILL_W'(WORD_W)) : merged_fill_c;
        acc_next_c    = merged_c & ((ACC_W'(1) << rem_fill_c) - ACC_W'(1));
        last_word_c   = (word_cnt_q == CNT_W'(WORDS_PER_PACKET - 1));
        mode_ok_c     = (mode <= 8'd2);
    end

    // Control FSM, packing state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mode_q       <= 2'd0;
            acc_q        <= '0;
            fill_q       <= '0;
            phase_q      <= 2'd0;
            word_cnt_q   <= '0;
            data         <= '0;
            en           <= 1'b0;
            packet_end   <= 1'b0;
            active       <= 1'b0;
            packet_count <= '0;
        end else begin
            data       <= '0;
            en         <= 1'b0;
            packet_end <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && mode_ok_c) begin
                        mode_q     <= mode[1:0];
                        acc_q      <= '0;
                        fill_q     <= '0;
                        phase_q    <= 2'd0;
                        word_cnt_q <= '0;
                        active     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_next_c;
                    fill_q  <= rem_fill_c;
                    phase_q <= phase_next_c;
                    if (emit_c) begin
                        en   <= 1'b1;
                        data <= word_c;
                        if (last_word_c) begin
                            packet_end   <= 1'b1;
                            word_cnt_q   <= '0;
                            packet_count <= packet_count + 16'd1;
                            // Boundary: fill is empty, so the format may change here
                            if (enable && mode_ok_c) begin
                                mode_q  <= mode[1:0];
                                phase_q <= 2'd0;
                            end else begin
                                active <= 1'b0;
                                state  <= IDLE;
                            end
                        end else begin
                            word_cnt_q <= word_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
